// File: rtl/button_reader_if.sv
// Button-side signal bundle for button_reader: the raw button level in,
// debounced level, event strobes and press count out.
interface button_reader_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   btn;
  logic                   pressed;
  logic                   press_pulse;
  logic                   release_pulse;
  logic                   long_pulse;
  logic [COUNT_WIDTH-1:0] press_count;

  modport master (
    output btn,
    input  pressed, press_pulse, release_pulse, long_pulse, press_count
  );

  modport slave (
    input  btn,
    output pressed, press_pulse, release_pulse, long_pulse, press_count
  );
endinterface

// File: rtl/button_reader.sv
// Debounced push-button reader: two-flop synchroniser, press/release debounce
// FSM, long-press detection and a wrapping press counter. All outputs registered.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic           clk,
  input  logic           reset,
  button_reader_if.slave btn_if
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic                   s1_q, s2_q;
  logic [DEB_W-1:0]       deb_q, deb_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   fired_q, fired_d;
  logic                   pressed_q, pressed_d;
  logic                   press_pulse_q, press_pulse_d;
  logic                   release_pulse_q, release_pulse_d;
  logic                   long_pulse_q, long_pulse_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      state_q         <= IDLE;
      deb_q           <= '0;
      hold_q          <= '0;
      fired_q         <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      count_q         <= '0;
    end else begin
      s1_q            <= btn_if.btn;
      s2_q            <= s1_q;
      state_q         <= state_d;
      deb_q           <= deb_d;
      hold_q          <= hold_d;
      fired_q         <= fired_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      count_q         <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (s2_q) state_d = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!s2_q)                 state_d = IDLE;
        else if (deb_q == DEB_MAX) state_d = HELD;
      end
      HELD:         if (!s2_q) state_d = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (s2_q)                  state_d = HELD;
        else if (deb_q == DEB_MAX) state_d = IDLE;
      end
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    deb_d           = deb_q;
    hold_d          = hold_q;
    fired_d         = fired_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    count_d         = count_q;
    case (state_q)
      IDLE: if (s2_q) deb_d = '0;
      PRESS_WAIT: begin
        if (s2_q) begin
          if (deb_q == DEB_MAX) begin
            pressed_d     = 1'b1;
            press_pulse_d = 1'b1;
            count_d       = count_q + COUNT_WIDTH'(1);
            hold_d        = '0;
            fired_d       = 1'b0;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
      end
      HELD: begin
        // hold_cnt stays frozen while in RELEASE_WAIT so a glitch resumes it
        if (!s2_q) begin
          deb_d = '0;
        end else if (hold_q == HOLD_MAX) begin
          if (!fired_q) begin
            long_pulse_d = 1'b1;
            fired_d      = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!s2_q) begin
          if (deb_q == DEB_MAX) begin
            pressed_d       = 1'b0;
            release_pulse_d = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign btn_if.pressed       = pressed_q;
  assign btn_if.press_pulse   = press_pulse_q;
  assign btn_if.release_pulse = release_pulse_q;
  assign btn_if.long_pulse    = long_pulse_q;
  assign btn_if.press_count   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: a run-length reference model predicts
// press/release/long events into a queue; a negedge monitor pops and compares.
module tb_button_reader;
  localparam int D  = 4;
  localparam int L  = 10;
  localparam int CW = 8;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int          kind;
    int unsigned cnt;
    int          cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  button_reader_if #(.COUNT_WIDTH(CW)) bif ();

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_if(bif)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: the debounced level flips once D+1 consecutive observed
  // samples (btn delayed two edges) disagree with it; a long press is the L-th
  // steady held edge after the press, not counting edges that end a glitch.
  int          m_h1 = 0, m_h2 = 0;
  int          m_level = 0, m_run = 0, m_hold = 0, m_fired = 0;
  int unsigned m_cnt = 0;
  ev_t         sb[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    int  seen;
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_h1 = 0; m_h2 = 0; m_level = 0; m_run = 0;
        m_hold = 0; m_fired = 0; m_cnt = 0;
      end else begin
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = (bif.btn === 1'b1) ? 1 : 0;
        if (seen != m_level) begin
          m_run++;
          if (m_run == D + 1) begin
            m_level = seen;
            m_run   = 0;
            if (m_level == 1) begin
              m_cnt   = (m_cnt + 1) % (1 << CW);
              m_hold  = 0;
              m_fired = 0;
              e.kind  = K_PRESS;
            end else begin
              e.kind = K_RELEASE;
            end
            e.cnt = m_cnt;
            e.cyc = cyc;
            sb.push_back(e);
          end
        end else begin
          if (m_level == 1 && m_run == 0) begin
            if (m_hold < L) m_hold++;
            if (m_hold == L && m_fired == 0) begin
              m_fired = 1;
              e.kind  = K_LONG;
              e.cnt   = m_cnt;
              e.cyc   = cyc;
              sb.push_back(e);
            end
          end
          m_run = 0;
        end
      end
    end
  end

  initial begin
    int  np, kind;
    ev_t e;
    forever begin
      @(negedge clk);
      chk("pressed", {31'b0, bif.pressed}, m_level);
      chk("press_count", {24'b0, bif.press_count}, m_cnt);
      np = int'(bif.press_pulse) + int'(bif.release_pulse) + int'(bif.long_pulse);
      chk("pulse_exclusive", (np > 1) ? 1 : 0, 0);
      if (np >= 1) begin
        kind = bif.press_pulse ? K_PRESS : (bif.release_pulse ? K_RELEASE : K_LONG);
        if (sb.size() == 0) begin
          chk("unexpected_pulse_kind", kind, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          chk("event_count", {24'b0, bif.press_count}, e.cnt);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("missing_pulse_kind", 32'hFFFF_FFFF, e.kind);
      end
    end
  end

  task automatic drive(logic v, int n);
    bif.btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bif.btn = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5);
    // clean press with long hold
    drive(1'b1, 40); drive(1'b0, 15);
    // bounce on press
    drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 15);
    // release with glitch
    drive(1'b1, 20); drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 15);
    // short press
    drive(1'b1, 10); drive(1'b0, 15);
    // press counter wrap
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 9); drive(1'b0, 9);
    end
    // reset mid-hold, button still held
    drive(1'b1, 20);
    bif.btn = 1'b1;
    pulse_reset();
    drive(1'b1, 20); drive(1'b0, 15);
    // randomized segments with occasional reset
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 18)));
    end
    drive(1'b0, 30);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Debounced push-button input reader; the input-side counterpart to our LED/pattern output drivers.
- Synchronises a raw board button and rejects bounce, then reports clean press, release and long-press events.
- Keeps a running press count, so top-level FSMs can step patterns from user input instead of a free-running divider.
- Sits between the board pin and the top-level control FSM, all in the 12 MHz `clk` domain.

Parameters:
- DEBOUNCE_CYCLES, 120000: cycles the synchronised input must be stable before a press or release is accepted (10 ms at 12 MHz). Must be >= 2.
- LONG_CYCLES, 12000000: cycles held after an accepted press before `long_pulse` fires (1 s). Must be >= 2.
- COUNT_WIDTH, 8: width of `press_count`.

Ports:
- clk  input  1  system clock, 12 MHz.
- reset  input  1  synchronous, active-high reset.
- btn  input  1  raw, asynchronous button level; 1 = pressed.
- pressed  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe when a press is accepted.
- release_pulse  output  1  one-cycle strobe when a release is accepted.
- long_pulse  output  1  one-cycle strobe, at most once per press.
- press_count  output  COUNT_WIDTH  number of accepted presses, wraps.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On a `clk` edge with `reset`=1: synchroniser flops=0, state=IDLE, all counters=0, long_fired=0.
  - All outputs go to 0: `pressed`, `press_pulse`, `release_pulse`, `long_pulse`, `press_count`.
  - Reset overrides every other event in that cycle.
- Synchroniser: two flops, `btn` -> s1 -> s2. The FSM sees only s2.
- All outputs are registered. Pulses are high for exactly one cycle.
- Counters:
  - deb_cnt is ceil(log2(DEBOUNCE_CYCLES)) bits.
  - hold_cnt is ceil(log2(LONG_CYCLES)) bits and saturates at LONG_CYCLES-1.
- State IDLE:
  - s2=1 -> PRESS_WAIT, deb_cnt<=0.
- State PRESS_WAIT:
  - s2=0 -> IDLE, with no output change (bounce rejected).
  - s2=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> HELD. Same edge: `pressed`<=1, `press_pulse`<=1, `press_count`<=`press_count`+1 (modulo 2^COUNT_WIDTH; all-ones wraps to 0), hold_cnt<=0, long_fired<=0.
  - Otherwise deb_cnt<=deb_cnt+1.
- State HELD:
  - s2=0 -> RELEASE_WAIT, deb_cnt<=0. hold_cnt freezes.
  - s2=1: if hold_cnt==LONG_CYCLES-1 and long_fired=0, then `long_pulse`<=1 and long_fired<=1. Otherwise hold_cnt increments, saturating.
- State RELEASE_WAIT:
  - s2=1 -> HELD. This is a glitch: no pulse, `pressed` stays 1, hold_cnt resumes from its frozen value.
  - s2=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE, `pressed`<=0, `release_pulse`<=1.
  - Otherwise deb_cnt<=deb_cnt+1.
- Latency:
  - Let edge 1 be the first edge sampling `btn`=1, with `btn` stable thereafter.
  - `press_pulse` and `pressed` are high after edge DEBOUNCE_CYCLES+3.
  - `long_pulse` follows exactly LONG_CYCLES cycles after `press_pulse`.
  - `release_pulse` is high DEBOUNCE_CYCLES+3 edges after the first edge sampling `btn`=0.
- Exclusivity:
  - At most one of `press_pulse`/`release_pulse`/`long_pulse` is high in any cycle.
  - `long_pulse` never fires after `release_pulse` for the same press.
- Reset with the button held: after `reset` deasserts, the press is re-detected with full latency and counted again.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, COUNT_WIDTH=8):
1. Clean press: `btn` 0->1, held 40 cycles -> `press_pulse` high for one cycle after edge 7. `pressed`=1 from then. `press_count`=1. `long_pulse` high for one cycle exactly 10 cycles after `press_pulse`, and only once.
2. Bounce on press: `btn` toggles 1,0,1,0 with 2-cycle periods, then stays 0 -> no pulses; `pressed`=0; `press_count`=0.
3. Release with glitch: from HELD, `btn`=0 for 2 cycles, 1 for 3, then 0 steadily -> no `release_pulse` for the glitch. `release_pulse` arrives after edge 7 of the final low period, then `pressed`=0.
4. Short press: press accepted, released 3 cycles after `press_pulse` -> `release_pulse` arrives, no `long_pulse`. `press_count` increments by 1.
5. Wrap: 256 clean press/release pairs -> `press_count` reads 255, then 0 after the 256th `press_pulse`.
6. Reset mid-hold: assert `reset` for 1 cycle while in HELD with `btn`=1 -> all outputs 0 on the next edge. With `btn` still 1, `press_pulse` is high after edge 7 post-reset and `press_count`=1.
